// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi core: activity-state encodings,
// default level width, per-state level deltas and ageing constants.
package tamagotchi_pkg;

   // Activity states driven by the state controller (one-hot, IDLE = all zero)
   typedef enum logic [3:0] {
      IDLE       = 4'b0000,
      DORMINDO   = 4'b0001,
      COMENDO    = 4'b0010,
      DANDO_AULA = 4'b0100,
      MORTO      = 4'b1000
   } estado_t;

   localparam int NIVEL_W_PADRAO = 7;

   // Per-tick deltas are small signed numbers; 4 bits covers -8..+7
   localparam int DELTA_W = 4;

   localparam logic signed [DELTA_W-1:0] D_ENERGIA_IDLE     = -4'sd1;
   localparam logic signed [DELTA_W-1:0] D_SACIEDADE_IDLE   = -4'sd1;
   localparam logic signed [DELTA_W-1:0] D_ENERGIA_DORMINDO = 4'sd2;
   localparam logic signed [DELTA_W-1:0] D_SACIEDADE_DORMINDO = -4'sd1;
   localparam logic signed [DELTA_W-1:0] D_ENERGIA_COMENDO  = -4'sd1;
   localparam logic signed [DELTA_W-1:0] D_SACIEDADE_COMENDO = 4'sd3;
   localparam logic signed [DELTA_W-1:0] D_ENERGIA_AULA     = -4'sd2;
   localparam logic signed [DELTA_W-1:0] D_SACIEDADE_AULA   = -4'sd2;

   // Ageing: one age unit every 60 ticks, death at age 200
   localparam int TICKS_POR_IDADE = 60;
   localparam int IDADE_MORTE     = 200;

   typedef struct packed {
      logic signed [DELTA_W-1:0] d_energia;
      logic signed [DELTA_W-1:0] d_saciedade;
   } deltas_t;

   // Unknown or multi-hot encodings fall back to the IDLE deltas; MORTO is
   // handled by the caller (levels frozen), so its value here is irrelevant.
   function automatic deltas_t deltas_de(input logic [3:0] estado);
      deltas_t d;
      case (estado)
         DORMINDO: begin
            d.d_energia   = D_ENERGIA_DORMINDO;
            d.d_saciedade = D_SACIEDADE_DORMINDO;
         end
         COMENDO: begin
            d.d_energia   = D_ENERGIA_COMENDO;
            d.d_saciedade = D_SACIEDADE_COMENDO;
         end
         DANDO_AULA: begin
            d.d_energia   = D_ENERGIA_AULA;
            d.d_saciedade = D_SACIEDADE_AULA;
         end
         default: begin
            d.d_energia   = D_ENERGIA_IDLE;
            d.d_saciedade = D_SACIEDADE_IDLE;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/gerador_tick.sv
// Parameterised prescaler: counts 0..TICK_DIV-1 and raises a one-cycle
// tick while the count sits at TICK_DIV-1. Async active-high reset.
module gerador_tick #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap to zero on the tick cycle
   always_comb begin
      tick  = (cnt_q == CNT_MAX);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Counter register; reset discards any partial period
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gerenciador_necessidades.sv
// Needs manager: on each tick applies the per-state deltas to energia and
// saciedade with clamping to [0, MAX_NIVEL], raises alerts and a sticky
// death flag. Optional ageing is enabled by defining ENVELHECIMENTO_EN.
module gerenciador_necessidades
   import tamagotchi_pkg::*;
#(
   parameter int TICK_DIV      = 50000000,
   parameter int MAX_NIVEL     = 100,
   parameter int LIMIAR_ALERTA = 20,
   parameter int NIVEL_W       = NIVEL_W_PADRAO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         estado,
   output logic [NIVEL_W-1:0] energia,
   output logic [NIVEL_W-1:0] saciedade,
   output logic               alerta_sono,
   output logic               alerta_fome,
   output logic               morreu,
   output logic [7:0]         idade
);

   localparam int SW = NIVEL_W + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(MAX_NIVEL);
   localparam logic [NIVEL_W-1:0] MAX_N = NIVEL_W'(MAX_NIVEL);
   localparam logic [NIVEL_W-1:0] LIM_N = NIVEL_W'(LIMIAR_ALERTA);

   logic               tick;
   logic [NIVEL_W-1:0] energia_q, energia_d;
   logic [NIVEL_W-1:0] saciedade_q, saciedade_d;
   logic               morreu_q, morreu_d;
   logic               morte_idade;
   deltas_t            deltas;
   logic signed [SW-1:0] e_soma, s_soma;

   gerador_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_gerador_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Clamp a signed sum into [0, MAX_NIVEL]
   function automatic logic [NIVEL_W-1:0] satura(input logic signed [SW-1:0] v);
      if (v < 0)          return '0;
      else if (v > MAX_S) return MAX_N;
      else                return v[NIVEL_W-1:0];
   endfunction

`ifdef ENVELHECIMENTO_EN
   logic [5:0] cnt_idade_q, cnt_idade_d;
   logic [7:0] idade_q, idade_d;

   // Age counter: one age unit per 60 live ticks, saturating at 255
   always_comb begin
      cnt_idade_d = cnt_idade_q;
      idade_d     = idade_q;
      if (!morreu_q && tick) begin
         if (cnt_idade_q == 6'(TICKS_POR_IDADE - 1)) begin
            cnt_idade_d = '0;
            if (idade_q != 8'hFF) idade_d = idade_q + 8'd1;
         end else begin
            cnt_idade_d = cnt_idade_q + 6'd1;
         end
      end
      morte_idade = (idade_d != idade_q) && (idade_d == 8'(IDADE_MORTE));
   end

   // Age registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_idade_q <= '0;
         idade_q     <= '0;
      end else begin
         cnt_idade_q <= cnt_idade_d;
         idade_q     <= idade_d;
      end
   end

   assign idade = idade_q;
`else
   assign morte_idade = 1'b0;
   assign idade       = '0;
`endif

   // Next levels and death flag; everything freezes once morreu is set
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      deltas      = deltas_de(estado);
      e_soma      = $signed({2'b00, energia_q})
                  + $signed({{(SW-DELTA_W){deltas.d_energia[DELTA_W-1]}}, deltas.d_energia});
      s_soma      = $signed({2'b00, saciedade_q})
                  + $signed({{(SW-DELTA_W){deltas.d_saciedade[DELTA_W-1]}}, deltas.d_saciedade});
      energia_d   = energia_q;
      saciedade_d = saciedade_q;
      morreu_d    = morreu_q;
      if (!morreu_q) begin
         if (estado == MORTO) begin
            morreu_d = 1'b1;
         end else if (tick) begin
            energia_d   = satura(e_soma);
            saciedade_d = satura(s_soma);
            if (energia_d == '0 || saciedade_d == '0) morreu_d = 1'b1;
         end
         if (morte_idade) morreu_d = 1'b1;
      end
   end

   // Level and death registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         energia_q   <= MAX_N;
         saciedade_q <= MAX_N;
         morreu_q    <= 1'b0;
      end else begin
         energia_q   <= energia_d;
         saciedade_q <= saciedade_d;
         morreu_q    <= morreu_d;
      end
   end

   assign energia     = energia_q;
   assign saciedade   = saciedade_q;
   assign morreu      = morreu_q;
   assign alerta_sono = (energia_q <= LIM_N);
   assign alerta_fome = (saciedade_q <= LIM_N);

endmodule

// File: tb/tb_gerenciador_necessidades.sv
// Self-checking bench for gerenciador_necessidades (TICK_DIV=4, MAX_NIVEL=10,
// LIMIAR_ALERTA=3, NIVEL_W=4). Directed scenarios plus randomized estado
// sequences against a behavioural model. Honors ENVELHECIMENTO_EN.
module tb_gerenciador_necessidades;

   localparam int TICK_DIV = 4;
   localparam int MAX_NIVEL = 10;
   localparam int LIMIAR = 3;
   localparam int NIVEL_W = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [3:0]         estado = 4'b0000;
   logic [NIVEL_W-1:0] energia, saciedade;
   logic               alerta_sono, alerta_fome, morreu;
   logic [7:0]         idade;

   int total = 0;
   int bad = 0;

   // behavioural model state
   int m_cyc, m_e, m_s, m_idade, m_ticks;
   bit m_dead;

   gerenciador_necessidades #(
      .TICK_DIV(TICK_DIV), .MAX_NIVEL(MAX_NIVEL),
      .LIMIAR_ALERTA(LIMIAR), .NIVEL_W(NIVEL_W)
   ) dut (
      .clk(clk), .rst(rst), .estado(estado),
      .energia(energia), .saciedade(saciedade),
      .alerta_sono(alerta_sono), .alerta_fome(alerta_fome),
      .morreu(morreu), .idade(idade)
   );

   always #5 clk = ~clk;

   function automatic int clampv(input int v);
      if (v < 0) return 0;
      if (v > MAX_NIVEL) return MAX_NIVEL;
      return v;
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_e = MAX_NIVEL; m_s = MAX_NIVEL;
      m_idade = 0; m_ticks = 0; m_dead = 0;
   endtask

   // One rising edge of the model with the estado seen at that edge
   task automatic model_edge(input logic [3:0] est);
      bit t;
      int de, ds;
      m_cyc++;
      t = (m_cyc % TICK_DIV) == 0;
      if (!m_dead) begin
         case (est)
            4'b0001: begin de = 2;  ds = -1; end
            4'b0010: begin de = -1; ds = 3;  end
            4'b0100: begin de = -2; ds = -2; end
            default: begin de = -1; ds = -1; end
         endcase
`ifdef ENVELHECIMENTO_EN
         if (t) begin
            m_ticks++;
            if (m_ticks % 60 == 0 && m_idade < 255) begin
               m_idade++;
               if (m_idade == 200) m_dead = 1;
            end
         end
`endif
         if (est == 4'b1000) m_dead = 1;
         else if (t) begin
            m_e = clampv(m_e + de);
            m_s = clampv(m_s + ds);
            if (m_e == 0 || m_s == 0) m_dead = 1;
         end
      end
   endtask

   task automatic avanca(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge(estado);
         #1;
      end
   endtask

   task automatic aplica_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; estado = 4'b0000;
      model_reset();
      #1;
      total++; if (energia !== 4'd10) begin bad++; $display("FAIL reset_energia got=%0d exp=10", energia); end
      total++; if (saciedade !== 4'd10) begin bad++; $display("FAIL reset_saciedade got=%0d exp=10", saciedade); end
      total++; if ({morreu, alerta_sono, alerta_fome} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {morreu, alerta_sono, alerta_fome}); end
      total++; if (idade !== 8'd0) begin bad++; $display("FAIL reset_idade got=%0d exp=0", idade); end
      @(negedge clk);
      rst = 1'b0;
      avanca(3);
      total++; if (energia !== 4'd10) begin bad++; $display("FAIL tick_antecipado got=%0d exp=10", energia); end
      avanca(1);
      total++; if (energia !== 4'd9 || saciedade !== 4'd9) begin bad++; $display("FAIL primeiro_tick got=%0d/%0d exp=9/9", energia, saciedade); end
   endtask

   task automatic test_decaimento_idle();
      aplica_reset();
      estado = 4'b0000;
      avanca(16);
      total++; if (energia !== 4'd6 || saciedade !== 4'd6 || alerta_sono || alerta_fome) begin bad++; $display("FAIL idle_4ticks got=%0d/%0d al=%b%b exp=6/6 al=00", energia, saciedade, alerta_sono, alerta_fome); end
      avanca(12);
      total++; if (energia !== 4'd3 || saciedade !== 4'd3 || !alerta_sono || !alerta_fome) begin bad++; $display("FAIL idle_7ticks got=%0d/%0d al=%b%b exp=3/3 al=11", energia, saciedade, alerta_sono, alerta_fome); end
   endtask

   task automatic test_recuperacao_morte();
      int exp_e[3] = '{8, 10, 10};
      int exp_s[3] = '{5, 4, 3};
      aplica_reset();
      estado = 4'b0000;
      avanca(16);
      estado = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         avanca(4);
         total++; if (energia !== 4'(exp_e[i]) || saciedade !== 4'(exp_s[i])) begin bad++; $display("FAIL dormindo_t%0d got=%0d/%0d exp=%0d/%0d", i, energia, saciedade, exp_e[i], exp_s[i]); end
      end
      estado = 4'b0100;
      avanca(4);
      total++; if (energia !== 4'd8 || saciedade !== 4'd1 || morreu) begin bad++; $display("FAIL aula_t0 got=%0d/%0d m=%b exp=8/1 m=0", energia, saciedade, morreu); end
      avanca(4);
      total++; if (energia !== 4'd6 || saciedade !== 4'd0 || !morreu) begin bad++; $display("FAIL aula_clamp got=%0d/%0d m=%b exp=6/0 m=1", energia, saciedade, morreu); end
      estado = 4'b0010;
      avanca(12);
      total++; if (energia !== 4'd6 || saciedade !== 4'd0 || !morreu) begin bad++; $display("FAIL congelado got=%0d/%0d m=%b exp=6/0 m=1", energia, saciedade, morreu); end
   endtask

   task automatic test_invalido_reset_async();
      aplica_reset();
      estado = 4'b0011;
      avanca(4);
      total++; if (energia !== 4'd9 || saciedade !== 4'd9) begin bad++; $display("FAIL invalido got=%0d/%0d exp=9/9", energia, saciedade); end
      estado = 4'b0000;
      avanca(6);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      total++; if (energia !== 4'd10 || saciedade !== 4'd10 || morreu) begin bad++; $display("FAIL reset_async got=%0d/%0d m=%b exp=10/10 m=0", energia, saciedade, morreu); end
      #1;
      rst = 1'b0;
      avanca(3);
      total++; if (energia !== 4'd10) begin bad++; $display("FAIL pos_reset_cedo got=%0d exp=10", energia); end
      avanca(1);
      total++; if (energia !== 4'd9) begin bad++; $display("FAIL pos_reset_tick got=%0d exp=9", energia); end
      estado = 4'b1000;
      avanca(1);
      total++; if (!morreu || energia !== 4'd9) begin bad++; $display("FAIL morto m=%b e=%0d exp m=1 e=9", morreu, energia); end
   endtask

`ifdef ENVELHECIMENTO_EN
   task automatic test_envelhecimento();
      aplica_reset();
      for (int i = 0; i < 60; i++) begin
         estado = (i % 2 == 0) ? 4'b0010 : 4'b0001;
         avanca(4);
      end
      total++; if (idade !== 8'd1 || morreu) begin bad++; $display("FAIL idade_60 got=%0d m=%b exp=1 m=0", idade, morreu); end
   endtask
`endif

   task automatic test_aleatorio();
      int r;
      aplica_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25)      estado = 4'b0001;
         else if (r < 50) estado = 4'b0010;
         else if (r < 65) estado = 4'b0100;
         else if (r < 80) estado = 4'b0000;
         else if (r < 98) estado = 4'($urandom_range(0, 15));
         else             estado = 4'b1000;
         if ($urandom_range(0, 119) == 0) begin
            #2;
            rst = 1'b1;
            model_reset();
            #2;
            rst = 1'b0;
         end
         avanca(1);
         total++;
         if (energia !== 4'(m_e) || saciedade !== 4'(m_s) || morreu !== m_dead ||
             alerta_sono !== (m_e <= LIMIAR) || alerta_fome !== (m_s <= LIMIAR) || idade !== 8'(m_idade)) begin
            bad++;
            $display("FAIL aleatorio_c%0d got e=%0d s=%0d m=%b a=%b%b i=%0d exp e=%0d s=%0d m=%b i=%0d",
                     i, energia, saciedade, morreu, alerta_sono, alerta_fome, idade, m_e, m_s, m_dead, m_idade);
         end
         if (m_dead && $urandom_range(0, 3) == 0) aplica_reset();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_decaimento_idle();
      test_recuperacao_morte();
      test_invalido_reset_async();
`ifdef ENVELHECIMENTO_EN
      test_envelhecimento();
`endif
      test_aleatorio();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gerenciador_necessidades.md
Name: gerenciador_necessidades

Overview:
Periodic needs manager for the Tamagotchi core. It consumes the 4-bit activity state (`estado`) from the state controller and, on each internal time tick, updates two saturating need levels: `energia` (energy) and `saciedade` (satiety). It drives the `morreu` input of the state controller and the alert outputs for display/LEDs. It schedules every level update: decay, recovery and death detection.

Parameters:
- TICK_DIV, 50000000: clock cycles per update tick (1 s at 50 MHz); minimum 2.
- MAX_NIVEL, 100: full-scale value of each level.
- LIMIAR_ALERTA, 20: a level at or below this value raises its alert.
- NIVEL_W, 7: level width; must satisfy 2^NIVEL_W > MAX_NIVEL.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- estado  input  4  activity state: IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- energia  output  NIVEL_W  current energy level.
- saciedade  output  NIVEL_W  current satiety level.
- alerta_sono  output  1  energia <= LIMIAR_ALERTA.
- alerta_fome  output  1  saciedade <= LIMIAR_ALERTA.
- morreu  output  1  death flag; sticky.
- idade  output  8  age in ages-units (only meaningful with the optional feature).

Behaviour:
- Reset (async, immediate):
  - energia = saciedade = MAX_NIVEL.
  - morreu = 0, alerts = 0, idade = 0.
  - tick counter = 0.
- Tick:
  - Counter runs 0..TICK_DIV-1.
  - `tick` is asserted for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.
  - The first tick after reset release occurs on the TICK_DIV-th rising edge.
- Level update happens on the edge where `tick` = 1. The per-tick delta depends on `estado`:
  - IDLE: energia -1, saciedade -1.
  - DORMINDO: energia +2, saciedade -1.
  - COMENDO: energia -1, saciedade +3.
  - DANDO_AULA: energia -2, saciedade -2.
  - MORTO: no change; morreu is set to 1 on the next edge, with or without a tick.
  - Any other encoding (including multi-hot) is treated as IDLE.
- Arithmetic:
  - Computed in NIVEL_W+2 signed bits.
  - Result is clamped to [0, MAX_NIVEL]; no wrap-around.
- Death:
  - morreu is registered and goes to 1 on the same edge that either level's next value is 0.
  - Once set, morreu remains 1 until rst; all levels and idade freeze.
- Alerts:
  - Combinational compare of the registered levels.
  - They therefore change in the same cycle the level changes.
- Latency: one clock from tick to visible level, alert and morreu change.
- Simultaneous events:
  - A tick and a change of `estado` on the same edge use the `estado` value sampled at that edge.
  - Both levels reaching 0 on the same tick is a single death event.
- Reset mid-tick: the counter is cleared and the partial period is discarded.

Optional Feature:
ENVELHECIMENTO_EN
- Defined:
  - An internal counter increments `idade` once every 60 ticks, saturating at 255.
  - When `idade` reaches 200, morreu is set on that edge (same sticky rules as level death).
- Undefined: `idade` is tied to 0 and age has no effect on morreu.

Decomposition:
- Package `tamagotchi_pkg`:
  - estado encodings IDLE/DORMINDO/COMENDO/DANDO_AULA/MORTO.
  - Default NIVEL_W.
  - Per-state delta constants.
  - Ages-unit ticks (60) and death age (200).
- Sub-module `gerador_tick`:
  - Parameterised prescaler, TICK_DIV in, one-cycle `tick` out.
  - Async active-high reset.
  - Reused later by display blink logic.

Test Plan (TICK_DIV=4, MAX_NIVEL=10, LIMIAR_ALERTA=3, NIVEL_W=4):
- Reset check:
  - Assert rst → energia=10, saciedade=10, morreu=0, alerts=0, idade=0.
  - Release rst → first level change after exactly 4 clocks.
- Decay in IDLE: hold IDLE for 16 clocks (4 ticks) → energia=6, saciedade=6, alerts=0; 3 further ticks → both 3, both alerts=1.
- Recovery and saturation: from energia=6, saciedade=6, hold DORMINDO for 3 ticks → energia 8, 10, 10 (saturated); saciedade 5, 4, 3.
- Clamp and death:
  - From saciedade=3, hold DANDO_AULA for 2 ticks → saciedade 1, then 0 (clamped).
  - morreu=1 on that edge.
  - Switch to COMENDO for 3 ticks → morreu stays 1 and levels stay frozen.
- Invalid state and async reset:
  - estado=0011 for 1 tick → both levels -1, as in IDLE.
  - Pulse rst between clock edges mid-period → outputs reset without a clock edge; next tick comes 4 clocks after release.
- With ENVELHECIMENTO_EN:
  - Hold COMENDO with energia kept alive via alternation.
  - After 60 ticks → idade=1.
  - Force idade to 199, run 60 ticks → idade=200 and morreu=1.
